// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC controller for the instruction-fetch stage.
// Each cycle it selects what the program counter loads: reset vector,
// sequential +4, a redirect from EX, a hold for a hazard stall, or a halt.
// It also drives the IF/ID flush and fetch-valid qualifiers.
//
// Optional feature macro: PC_MISALIGN_TRAP_EN
//   defined   : a redirect to a misaligned target goes to TRAP_VEC and pulses trap
//   undefined : redirect targets are force-aligned, trap is tied low
//
// Ports:
//   clk         clock, rising edge
//   rst         asynchronous active-high reset
//   curr_addr   current PC value
//   stall       hazard unit requests PC hold
//   br_taken    EX resolved a taken branch/jump this cycle
//   br_target   redirect address, valid with br_taken
//   halt        EX decoded a halt instruction
//   next_addr   value for the PC to load (combinational)
//   pc_we       PC load enable (combinational)
//   flush       squash IF/ID contents (combinational)
//   fetch_valid fetched instruction is architecturally valid (combinational)
//   trap        misaligned-redirect trap pulse (combinational)
//   state       FSM state: BOOT=0, RUN=1, FLUSH=2, HALT=3
//   fetch_cnt   saturating count of valid fetches (registered)
module pc_sequencer #(
  parameter int unsigned          ADDR_W       = 8,
  parameter logic [ADDR_W-1:0]    RESET_ADDR   = ADDR_W'(8'h00),
  parameter logic [ADDR_W-1:0]    TRAP_VEC     = ADDR_W'(8'h40),
  parameter int unsigned          FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] curr_addr,
  input  logic              stall,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              halt,
  output logic [ADDR_W-1:0] next_addr,
  output logic              pc_we,
  output logic              flush,
  output logic              fetch_valid,
  output logic              trap,
  output logic [1:0]        state,
  output logic [15:0]       fetch_cnt
);

  localparam int unsigned BCNT_W = 3;
  localparam int unsigned CNT_W  = 16;
  localparam bit          MULTI_FLUSH = (FLUSH_CYCLES > 1);
  localparam logic [BCNT_W-1:0] BCNT_LOAD = BCNT_W'(MULTI_FLUSH ? FLUSH_CYCLES - 2 : 0);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
  logic [ADDR_W-1:0]   seq_addr;
  logic [ADDR_W-1:0]   redir_addr;
  logic                redir_trap;

  assign seq_addr = curr_addr + ADDR_W'(4);

  // Redirect target resolution for misaligned branch targets
`ifdef PC_MISALIGN_TRAP_EN
  assign redir_trap = |br_target[1:0];
  assign redir_addr = redir_trap ? TRAP_VEC : br_target;
`else
  assign redir_trap = 1'b0;
  assign redir_addr = br_target & ALIGN_MASK;
`endif

  // Next-state and combinational outputs
  always_comb begin
    state_d     = state_q;
    bcnt_d      = bcnt_q;
    next_addr   = curr_addr;
    pc_we       = 1'b0;
    flush       = 1'b0;
    fetch_valid = 1'b0;
    trap        = 1'b0;
    case (state_q)
      ST_BOOT: begin
        next_addr = RESET_ADDR;
        pc_we     = 1'b1;
        flush     = 1'b1;
        state_d   = ST_RUN;
      end
      ST_RUN: begin
        if (br_taken) begin
          next_addr = redir_addr;
          trap      = redir_trap;
          pc_we     = 1'b1;
          flush     = 1'b1;
          if (MULTI_FLUSH) begin
            state_d = ST_FLUSH;
            bcnt_d  = BCNT_LOAD;
          end
        end else if (halt) begin
          flush   = 1'b1;
          state_d = ST_HALT;
        end else if (stall) begin
          fetch_valid = 1'b1;
        end else begin
          next_addr   = seq_addr;
          pc_we       = 1'b1;
          fetch_valid = 1'b1;
        end
      end
      ST_FLUSH: begin
        // Events here come from squashed instructions and are ignored
        next_addr = seq_addr;
        pc_we     = 1'b1;
        flush     = 1'b1;
        if (bcnt_q == '0) state_d = ST_RUN;
        else              bcnt_d  = bcnt_q - BCNT_W'(1);
      end
      ST_HALT: begin
        flush = 1'b1;
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  // State, bubble counter and fetch counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_BOOT;
      bcnt_q    <= '0;
      fetch_cnt <= '0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      if (fetch_valid && (fetch_cnt != CNT_MAX)) fetch_cnt <= fetch_cnt + CNT_W'(1);
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  localparam logic [1:0] S_BOOT = 2'd0, S_RUN = 2'd1, S_FLUSH = 2'd2, S_HALT = 2'd3;
`ifdef PC_MISALIGN_TRAP_EN
  localparam logic [7:0] MIS_DST  = 8'h40;
  localparam logic       MIS_TRAP = 1'b1;
`else
  localparam logic [7:0] MIS_DST  = 8'h20;
  localparam logic       MIS_TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  curr_addr;
  logic        stall, br_taken, halt;
  logic [7:0]  br_target;
  logic [7:0]  next_addr;
  logic        pc_we, flush, fetch_valid, trap;
  logic [1:0]  state;
  logic [15:0] fetch_cnt;

  // bench-side program counter register, with a direct-load override
  logic        force_en;
  logic [7:0]  force_val;
  logic [7:0]  pc;

  typedef struct {
    string       nm;
    logic [7:0]  na;
    logic        we;
    logic        fl;
    logic        fv;
    logic        tr;
    logic [1:0]  st;
    logic [15:0] cnt;
    logic [7:0]  pc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk(clk), .rst(rst), .curr_addr(curr_addr), .stall(stall),
    .br_taken(br_taken), .br_target(br_target), .halt(halt),
    .next_addr(next_addr), .pc_we(pc_we), .flush(flush),
    .fetch_valid(fetch_valid), .trap(trap), .state(state), .fetch_cnt(fetch_cnt)
  );

  always @(posedge clk or posedge rst) begin
    if (rst)           pc <= 8'h00;
    else if (force_en) pc <= force_val;
    else if (pc_we)    pc <= next_addr;
  end
  assign curr_addr = pc;

  task automatic chk(input string nm, input string fld, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s.%s got=%h want=%h", nm, fld, act, exp);
    end
  endtask

  // monitor: pops one expectation per cycle, sampled mid-cycle
  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.nm, "next_addr",   16'(next_addr),   16'(e.na));
      chk(e.nm, "pc_we",       16'(pc_we),       16'(e.we));
      chk(e.nm, "flush",       16'(flush),       16'(e.fl));
      chk(e.nm, "fetch_valid", 16'(fetch_valid), 16'(e.fv));
      chk(e.nm, "trap",        16'(trap),        16'(e.tr));
      chk(e.nm, "state",       16'(state),       16'(e.st));
      chk(e.nm, "fetch_cnt",   fetch_cnt,        e.cnt);
      chk(e.nm, "pc",          16'(pc),          16'(e.pc));
    end
  end

  task automatic expect_cyc(input string nm, input logic [7:0] na, input logic we, input logic fl,
                            input logic fv, input logic tr, input logic [1:0] st,
                            input logic [15:0] cnt, input logic [7:0] pcv);
    exp_t e;
    e.nm = nm; e.na = na; e.we = we; e.fl = fl; e.fv = fv; e.tr = tr;
    e.st = st; e.cnt = cnt; e.pc = pcv;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    stall = 0; br_taken = 0; halt = 0; br_target = 8'h00; force_en = 0; force_val = 8'h00;
  endtask

  initial begin
    rst = 1;
    idle_in();
    repeat (2) @(posedge clk);
    #1;
    expect_cyc("in_reset", 8'h00, 1, 1, 0, 0, S_BOOT, 16'd0, 8'h00);
    rst = 0;
    // boot then sequential fetch 0,4,8,12,16
    expect_cyc("boot",  8'h00, 1, 1, 0, 0, S_BOOT, 16'd0, 8'h00);
    expect_cyc("seq4",  8'h04, 1, 0, 1, 0, S_RUN,  16'd0, 8'h00);
    expect_cyc("seq8",  8'h08, 1, 0, 1, 0, S_RUN,  16'd1, 8'h04);
    expect_cyc("seq12", 8'h0C, 1, 0, 1, 0, S_RUN,  16'd2, 8'h08);
    expect_cyc("seq16", 8'h10, 1, 0, 1, 0, S_RUN,  16'd3, 8'h0C);
    // branch to 0x20 at N; second branch at N+1 must be ignored
    br_taken = 1; br_target = 8'h20;
    expect_cyc("br_n",  8'h20, 1, 1, 0, 0, S_RUN,   16'd4, 8'h10);
    br_taken = 1; br_target = 8'h80;
    expect_cyc("br_n1", 8'h24, 1, 1, 0, 0, S_FLUSH, 16'd4, 8'h20);
    idle_in();
    force_en = 1; force_val = 8'h10;
    expect_cyc("br_n2", 8'h28, 1, 0, 1, 0, S_RUN,   16'd4, 8'h24);
    // stall held 3 cycles at 0x10
    idle_in();
    stall = 1;
    expect_cyc("stall0", 8'h10, 0, 0, 1, 0, S_RUN, 16'd5, 8'h10);
    expect_cyc("stall1", 8'h10, 0, 0, 1, 0, S_RUN, 16'd6, 8'h10);
    expect_cyc("stall2", 8'h10, 0, 0, 1, 0, S_RUN, 16'd7, 8'h10);
    idle_in();
    force_en = 1; force_val = 8'hFC;
    expect_cyc("unstall", 8'h14, 1, 0, 1, 0, S_RUN, 16'd8, 8'h10);
    // address wrap
    idle_in();
    expect_cyc("wrap", 8'h00, 1, 0, 1, 0, S_RUN, 16'd9, 8'hFC);
    // misaligned redirect target
    br_taken = 1; br_target = 8'h22;
    expect_cyc("mis_br",  MIS_DST,             1, 1, 0, MIS_TRAP, S_RUN,   16'd10, 8'h00);
    idle_in();
    expect_cyc("mis_fl",  MIS_DST + 8'h04,     1, 1, 0, 0,        S_FLUSH, 16'd10, MIS_DST);
    expect_cyc("mis_run", MIS_DST + 8'h08,     1, 0, 1, 0,        S_RUN,   16'd10, MIS_DST + 8'h04);
    // halt beats stall
    halt = 1; stall = 1;
    expect_cyc("halt_go", MIS_DST + 8'h08, 0, 1, 0, 0, S_RUN, 16'd11, MIS_DST + 8'h08);
    idle_in();
    for (int i = 0; i < 10; i++) begin
      br_taken = (i == 3); br_target = 8'h30; stall = (i == 5);
      expect_cyc($sformatf("halt%0d", i), MIS_DST + 8'h08, 0, 1, 0, 0, S_HALT, 16'd11, MIS_DST + 8'h08);
    end
    idle_in();
    // asynchronous reset in HALT
    rst = 1;
    expect_cyc("rst_halt", 8'h00, 1, 1, 0, 0, S_BOOT, 16'd0, 8'h00);
    rst = 0;
    expect_cyc("reboot", 8'h00, 1, 1, 0, 0, S_BOOT, 16'd0, 8'h00);
    expect_cyc("rerun",  8'h04, 1, 0, 1, 0, S_RUN,  16'd0, 8'h00);
    // bounded drain of the scoreboard
    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      $display("FAIL drain left=%0d want=0", q.size());
      $fatal(1, "scoreboard did not drain");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Next-PC controller for the instruction-fetch stage. Each cycle it chooses the value the program counter loads: sequential `+4`, a branch/jump redirect from EX, a hold for a hazard stall, or a halt. It also drives the IF/ID flush and fetch-valid qualifiers. It sits between the hazard unit / EX branch resolution and the `program_counter` register, whose `next_addr` input it drives.

## Interface
- `ADDR_W`, 8, address width; matches the PC register.
- `RESET_ADDR`, 8'h00, first fetch address after reset.
- `TRAP_VEC`, 8'h40, redirect target for a misaligned branch (only with `PC_MISALIGN_TRAP_EN`).
- `FLUSH_CYCLES`, 2, bubble cycles per redirect (legal 1..7), the redirect cycle included.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `curr_addr`  in  ADDR_W  current PC value.
- `stall`  in  1  hazard unit requests PC hold.
- `br_taken`  in  1  EX resolved a taken branch/jump this cycle.
- `br_target`  in  ADDR_W  redirect address; valid with `br_taken`.
- `halt`  in  1  EX decoded a halt instruction.
- `next_addr`  out  ADDR_W  value for the PC to load.
- `pc_we`  out  1  PC load enable.
- `flush`  out  1  squash the IF/ID contents.
- `fetch_valid`  out  1  instruction fetched this cycle is architecturally valid.
- `trap`  out  1  misaligned-redirect trap pulse.
- `state`  out  2  FSM state: BOOT=0, RUN=1, FLUSH=2, HALT=3.
- `fetch_cnt`  out  16  count of valid fetches.

## Operation
- Registered state:
  - FSM `state`.
  - Bubble counter `bcnt` (3 bits).
  - `fetch_cnt`.
- All other outputs are combinational from the state and the inputs.
- Reset, and while `rst`=1:
  - `state`=BOOT, `bcnt`=0, `fetch_cnt`=0.
  - Outputs: `next_addr`=RESET_ADDR, `pc_we`=1, `flush`=1, `fetch_valid`=0, `trap`=0.
- **BOOT**: outputs as at reset; moves to RUN unconditionally on the next edge.
- **RUN**: priority is `br_taken` > `halt` > `stall` > sequential.
  - `br_taken`: `next_addr`=`br_target` (alignment rule under Configuration), `pc_we`=1, `flush`=1, `fetch_valid`=0.
    - If FLUSH_CYCLES>1: go to FLUSH with `bcnt`=FLUSH_CYCLES-2.
    - Otherwise: stay in RUN.
  - `halt`: `pc_we`=0, `next_addr`=`curr_addr`, `fetch_valid`=0, `flush`=1; go to HALT.
  - `stall`: `pc_we`=0, `next_addr`=`curr_addr`, `flush`=0, `fetch_valid`=1.
  - Sequential: `next_addr`=`curr_addr`+4 modulo 2^ADDR_W (252+4 = 0), `pc_we`=1, `flush`=0, `fetch_valid`=1.
- **FLUSH**:
  - Outputs: `next_addr`=`curr_addr`+4, `pc_we`=1, `flush`=1, `fetch_valid`=0.
  - `br_taken`, `halt` and `stall` are ignored, because they originate from squashed instructions.
  - If `bcnt`=0: go to RUN. Otherwise decrement `bcnt`.
- **HALT**: `pc_we`=0, `next_addr`=`curr_addr`, `flush`=1, `fetch_valid`=0. The block leaves HALT only through `rst`.
- `fetch_cnt` increments on each edge where `fetch_valid`=1 and saturates at 16'hFFFF.
- A `stall` held across many cycles keeps `curr_addr` unchanged and counts one valid fetch per cycle.

## Timing
- Input-to-output is zero-latency (combinational) within the cycle.
- A branch with `br_taken` in cycle N:
  - The PC holds `br_target` after edge N.
  - `flush` is high in cycles N .. N+FLUSH_CYCLES-1.
  - `fetch_valid` returns high in cycle N+FLUSH_CYCLES.
- `rst` asserted mid-FLUSH or mid-HALT forces BOOT immediately (asynchronously). The first fetch after reset release is at RESET_ADDR; `fetch_valid` goes high one cycle after BOOT.
- `br_taken` and `stall` together in RUN: the redirect wins, and the stall is dropped.

## Configuration
- `PC_MISALIGN_TRAP_EN` defined:
  - A redirect whose `br_target[1:0]`≠0 gives `next_addr`=TRAP_VEC and `trap`=1 for that cycle only.
  - Flush sequencing is the same as for a normal redirect.
- `PC_MISALIGN_TRAP_EN` undefined:
  - `next_addr` = {`br_target`[ADDR_W-1:2], 2'b00}.
  - `trap` is tied to 0.

## Test plan
- Reset, release, run 5 cycles:
  - `next_addr` sequence is 0, 4, 8, 12, 16.
  - `state` goes BOOT→RUN.
  - `fetch_cnt`=4 after cycle 5.
- `curr_addr`=8'hFC, no events: `next_addr`=8'h00 (wrap).
- `br_taken`=1, `br_target`=8'h20 at cycle N, FLUSH_CYCLES=2:
  - PC=8'h20 after edge N.
  - `flush` high in N and N+1.
  - `fetch_valid` high in N+2.
  - A `br_taken` injected at N+1 is ignored.
- `stall` held 3 cycles at PC=8'h10:
  - `pc_we`=0 throughout.
  - `next_addr`=8'h10.
  - `fetch_cnt` advances by 3.
- `halt`=1 with `stall`=1:
  - State goes to HALT, with `pc_we`=0 and `flush`=1 held for 10 cycles.
  - Asserting `rst` mid-HALT gives `state`=BOOT and `next_addr`=RESET_ADDR immediately.
- `br_target`=8'h22:
  - With the macro: `next_addr`=8'h40, `trap`=1 for one cycle.
  - Without the macro: `next_addr`=8'h20, `trap`=0.
